ex_rate_shaper: RTL and testbench



---
 rtl/ex_shaper_pkg.sv | 19 +
 rtl/ex_sync_fifo.sv | 52 +++++
 rtl/ex_rate_shaper.sv | 102 ++++++++++
 tb/tb_ex_rate_shaper.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_shaper_pkg.sv
// Shared types and defaults for the byte-stream rate shaper.
// The optional drop counter is enabled with the EX_SHAPER_STATS_EN macro.
package ex_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_GAP   = 2;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ex_sync_fifo.sv
// DEPTH x 8 synchronous FIFO with occupancy count; reset is synchronous, active-high.
// A push while full is accepted only if a pop happens at the same edge.
module ex_sync_fifo
  import ex_shaper_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [7:0]                wdata,
  output logic [7:0]                rdata,
  output logic [level_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ex_rate_shaper.sv
// Rate shaper: buffers incoming bytes and re-emits them with at least GAP idle cycles between pulses.
// Optional EX_SHAPER_STATS_EN adds o_drop_cnt, a saturating count of dropped bytes.
module ex_rate_shaper
  import ex_shaper_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                i_data,
  input  logic                      i_valid,
  output logic [7:0]                o_data,
  output logic                      o_valid,
  output logic [level_w(DEPTH)-1:0] o_level,
  output logic                      o_overflow,
`ifdef EX_SHAPER_STATS_EN
  output logic [7:0]                o_drop_cnt,
`endif
  output state_t                    o_dbg_state
);

  // Valid-only streams: a byte moves whenever its valid is high; there is no ready,
  // so an input byte that cannot be stored is dropped and o_overflow latches.
  // rst_n is asserted high despite its name.

  localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [7:0] head;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       drop;

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      EMIT:    pop = (GAP == 0) && !empty;
      HOLD:    pop = (gap_cnt == 4'd0) && !empty;
      default: pop = 1'b0;
    endcase
  end

  assign push        = i_valid && (!full || pop);
  assign drop        = i_valid && !push;
  assign o_dbg_state = state;

  ex_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (i_data),
    .rdata (head),
    .count (o_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      gap_cnt    <= 4'd0;
      o_data     <= 8'h00;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= pop;
      if (pop) o_data <= head;
      if (drop) o_overflow <= 1'b1;
      case (state)
        IDLE: if (pop) state <= EMIT;
        EMIT: begin
          if (GAP > 0) begin
            state   <= HOLD;
            gap_cnt <= GAP_M1;
          end else if (!pop) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // Spacing between pops is one EMIT edge plus GAP HOLD edges.
          if (gap_cnt == 4'd0) state <= pop ? EMIT : IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EX_SHAPER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst_n)                          o_drop_cnt <= 8'd0;
    else if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ex_rate_shaper.sv
// Self-checking bench for ex_rate_shaper: GAP=2 and GAP=0 instances (plus a DEPTH=2/GAP=15 one with stats).
module tb_ex_rate_shaper;
  import ex_shaper_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // instance A: DEPTH=8 GAP=2
  logic [7:0] a_i_data = 8'h00;
  logic       a_i_valid = 1'b0;
  logic [7:0] a_o_data;
  logic       a_o_valid;
  logic [3:0] a_o_level;
  logic       a_o_overflow;
  logic [7:0] a_drop;
  state_t     a_state;

  // instance B: DEPTH=8 GAP=0
  logic [7:0] b_i_data = 8'h00;
  logic       b_i_valid = 1'b0;
  logic [7:0] b_o_data;
  logic       b_o_valid;
  logic [3:0] b_o_level;
  logic       b_o_overflow;
  logic [7:0] b_drop;
  state_t     b_state;

  ex_rate_shaper #(.DEPTH(8), .GAP(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_data(a_i_data), .i_valid(a_i_valid),
    .o_data(a_o_data), .o_valid(a_o_valid), .o_level(a_o_level), .o_overflow(a_o_overflow),
`ifdef EX_SHAPER_STATS_EN
    .o_drop_cnt(a_drop),
`endif
    .o_dbg_state(a_state)
  );

  ex_rate_shaper #(.DEPTH(8), .GAP(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_data(b_i_data), .i_valid(b_i_valid),
    .o_data(b_o_data), .o_valid(b_o_valid), .o_level(b_o_level), .o_overflow(b_o_overflow),
`ifdef EX_SHAPER_STATS_EN
    .o_drop_cnt(b_drop),
`endif
    .o_dbg_state(b_state)
  );

`ifdef EX_SHAPER_STATS_EN
  logic [7:0] c_i_data = 8'h00;
  logic       c_i_valid = 1'b0;
  logic [7:0] c_o_data;
  logic       c_o_valid;
  logic [1:0] c_o_level;
  logic       c_o_overflow;
  logic [7:0] c_drop;
  state_t     c_state;

  ex_rate_shaper #(.DEPTH(2), .GAP(15)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_data(c_i_data), .i_valid(c_i_valid),
    .o_data(c_o_data), .o_valid(c_o_valid), .o_level(c_o_level), .o_overflow(c_o_overflow),
    .o_drop_cnt(c_drop), .o_dbg_state(c_state)
  );
`else
  assign a_drop = 8'h00;
  assign b_drop = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboards
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         a_times[$];
  int         b_times[$];
  bit         mon_a = 1'b1;
  int         a_lvl_max = 0;

  always @(negedge clk) begin
    if (mon_a) begin
      if (int'(a_o_level) > a_lvl_max) a_lvl_max = int'(a_o_level);
      if (a_o_valid === 1'b1) begin
        a_times.push_back(cyc);
        if (exp_a.size() == 0) check("a_extra_byte", {24'h0, a_o_data}, 32'hFFFF_FFFF);
        else                   check("a_data", {24'h0, a_o_data}, {24'h0, exp_a.pop_front()});
      end
    end
    if (b_o_valid === 1'b1) begin
      b_times.push_back(cyc);
      if (exp_b.size() == 0) check("b_extra_byte", {24'h0, b_o_data}, 32'hFFFF_FFFF);
      else                   check("b_data", {24'h0, b_o_data}, {24'h0, exp_b.pop_front()});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    a_i_valid = 1'b0;
    b_i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic drive_a(input logic [7:0] d, input bit expect_out);
    @(negedge clk);
    a_i_valid = 1'b1;
    a_i_data  = d;
    if (expect_out) exp_a.push_back(d);
  endtask

  task automatic drive_b(input logic [7:0] d);
    @(negedge clk);
    b_i_valid = 1'b1;
    b_i_data  = d;
    exp_b.push_back(d);
  endtask

  task automatic drain_a(input int budget);
    int n = 0;
    while (exp_a.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_drain_timeout", exp_a.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    while (exp_b.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("b_drain_timeout", exp_b.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_times_a(input string tag, input int t_first, input int step, input int n);
    check({tag, "_pulse_count"}, a_times.size(), n);
    for (int k = 0; k < n && k < a_times.size(); k++)
      check({tag, "_pulse_time"}, a_times[k], t_first + step * k);
  endtask

  initial begin
    int t0;
    int n;

    // reset state
    do_reset();
    check("rst_valid", {31'h0, a_o_valid}, 0);
    check("rst_data", {24'h0, a_o_data}, 0);
    check("rst_level", {28'h0, a_o_level}, 0);
    check("rst_overflow", {31'h0, a_o_overflow}, 0);
    check("rst_state", 32'(a_state), 32'(IDLE));

    // single byte latency
    a_times.delete();
    drive_a(8'hA5, 1'b1);
    t0 = cyc;
    @(negedge clk);
    a_i_valid = 1'b0;
    check("t1_level_after_push", {28'h0, a_o_level}, 1);
    @(negedge clk);
    check("t1_valid", {31'h0, a_o_valid}, 1);
    check("t1_level_after_pop", {28'h0, a_o_level}, 0);
    drain_a(20);
    check_times_a("t1", t0 + 2, 3, 1);

    // four bytes, GAP=2
    a_times.delete();
    a_lvl_max = 0;
    for (int i = 0; i < 4; i++) begin
      drive_a(8'h10 + 8'(i), 1'b1);
      if (i == 0) t0 = cyc;
    end
    @(negedge clk);
    a_i_valid = 1'b0;
    drain_a(40);
    check_times_a("t2", t0 + 2, 3, 4);
    check("t2_level_peak", a_lvl_max, 3);
    check("t2_overflow", {31'h0, a_o_overflow}, 0);

    // overflow with 16 back-to-back bytes
    do_reset();
    a_times.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      if (i == 12) check("t3_overflow_before", {31'h0, a_o_overflow}, 0);
      if (i == 13) check("t3_overflow_after", {31'h0, a_o_overflow}, 1);
      a_i_valid = 1'b1;
      a_i_data  = 8'(i);
      if (i != 12 && i != 14 && i != 15) exp_a.push_back(8'(i));
    end
    @(negedge clk);
    a_i_valid = 1'b0;
    drain_a(100);
    check_times_a("t3", t0 + 2, 3, 13);
    check("t3_overflow_sticky", {31'h0, a_o_overflow}, 1);
`ifdef EX_SHAPER_STATS_EN
    check("t3_drop_cnt", {24'h0, a_drop}, 3);
`endif

    // GAP=0 back-to-back
    b_times.delete();
    for (int i = 0; i < 5; i++) begin
      drive_b(8'h21 + 8'(i));
      if (i == 0) t0 = cyc;
    end
    @(negedge clk);
    b_i_valid = 1'b0;
    drain_b(40);
    check("t4_pulse_count", b_times.size(), 5);
    for (int k = 0; k < 5 && k < b_times.size(); k++)
      check("t4_pulse_time", b_times[k], t0 + 2 + k);

    // reset mid-operation
    mon_a = 1'b0;
    for (int i = 0; i < 16; i++) drive_a(8'h80 + 8'(i), 1'b0);
    @(negedge clk);
    a_i_valid = 1'b0;
    n = 0;
    while (a_o_level != 4'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_level_reached", {28'h0, a_o_level}, 4);
    check("t5_overflow_set", {31'h0, a_o_overflow}, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("t5_valid", {31'h0, a_o_valid}, 0);
    check("t5_level", {28'h0, a_o_level}, 0);
    check("t5_overflow", {31'h0, a_o_overflow}, 0);
    check("t5_state", 32'(a_state), 32'(IDLE));
    exp_a.delete();
    a_times.delete();
    mon_a = 1'b1;
    drive_a(8'h5A, 1'b1);
    t0 = cyc;
    @(negedge clk);
    a_i_valid = 1'b0;
    drain_a(20);
    check_times_a("t5", t0 + 2, 3, 1);

`ifdef EX_SHAPER_STATS_EN
    // drop counter saturation, DEPTH=2 GAP=15
    do_reset();
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      if (i == 17) check("t6_drop_early", {24'h0, c_drop}, 14);
      c_i_valid = 1'b1;
      c_i_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    check("t6_drop_sat", {24'h0, c_drop}, 255);
    repeat (20) @(negedge clk);
    c_i_valid = 1'b0;
    @(negedge clk);
    check("t6_drop_hold", {24'h0, c_drop}, 255);
    check("t6_overflow", {31'h0, c_o_overflow}, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
